// File: rtl/even_odd_sorter.sv
`timescale 1ns/1ps
// even_odd_sorter: splits a 4-bit sample stream into two FIFOs by parity.
// Each FIFO is a DEPTH-entry circular buffer with a write pointer, a read
// pointer and an occupancy counter. Per-class accepted-sample counters
// saturate at their maximum value.
//
// Handshake rules (valid/ready, all ports):
//   - A transfer happens on a rising clk edge where valid && ready are both 1.
//   - in_ready never depends on in_valid or number in the same cycle.
//   - x_valid never depends on x_ready. A sample becomes visible on x_data
//     one edge after it is accepted.
//   - x_data shows the last popped value while x_valid is 0.
module even_odd_sorter #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [3:0]       number,
  output logic             in_ready,
  output logic             even_valid,
  input  logic             even_ready,
  output logic [3:0]       even_data,
  output logic             odd_valid,
  input  logic             odd_ready,
  output logic [3:0]       odd_data,
  output logic [CNT_W-1:0] even_count,
  output logic [CNT_W-1:0] odd_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = PW + 1;
  localparam logic [OW-1:0]    OCC_FULL = OW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Even queue state
  logic [3:0]    r_even_mem [DEPTH];
  logic [PW-1:0] r_even_wr_ptr;
  logic [PW-1:0] r_even_rd_ptr;
  logic [OW-1:0] r_even_occ;
  logic [3:0]    r_even_last;

  // Odd queue state
  logic [3:0]    r_odd_mem [DEPTH];
  logic [PW-1:0] r_odd_wr_ptr;
  logic [PW-1:0] r_odd_rd_ptr;
  logic [OW-1:0] r_odd_occ;
  logic [3:0]    r_odd_last;

  // Counters
  logic [CNT_W-1:0] r_even_cnt;
  logic [CNT_W-1:0] r_odd_cnt;

  // Datapath control
  logic w_even_full;
  logic w_odd_full;
  logic w_accept;
  logic w_is_odd;
  logic w_even_push;
  logic w_odd_push;
  logic w_even_pop;
  logic w_odd_pop;

  // Handshake decode. rst_n gates in_ready so it drops the instant reset
  // asserts, and is high again by the first edge after release.
  always_comb begin
    w_even_full = (r_even_occ == OCC_FULL);
    w_odd_full  = (r_odd_occ == OCC_FULL);
    in_ready    = rst_n && !clr && !w_even_full && !w_odd_full;
    even_valid  = (r_even_occ != '0);
    odd_valid   = (r_odd_occ != '0);
    w_accept    = in_valid && in_ready;
    w_is_odd    = number[0];
    w_even_push = w_accept && !w_is_odd;
    w_odd_push  = w_accept && w_is_odd;
    w_even_pop  = even_valid && even_ready && !clr;
    w_odd_pop   = odd_valid && odd_ready && !clr;
  end

  // Head data: stored head while valid, otherwise the last popped value
  always_comb begin
    even_data = even_valid ? r_even_mem[r_even_rd_ptr] : r_even_last;
    odd_data  = odd_valid ? r_odd_mem[r_odd_rd_ptr] : r_odd_last;
  end

  // Even queue pointers, occupancy and last-popped value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_even_wr_ptr <= '0;
      r_even_rd_ptr <= '0;
      r_even_occ    <= '0;
      r_even_last   <= '0;
    end else if (clr) begin
      r_even_wr_ptr <= '0;
      r_even_rd_ptr <= '0;
      r_even_occ    <= '0;
    end else begin
      if (w_even_push) begin
        r_even_wr_ptr <= r_even_wr_ptr + PW'(1);
      end
      if (w_even_pop) begin
        r_even_rd_ptr <= r_even_rd_ptr + PW'(1);
        r_even_last   <= r_even_mem[r_even_rd_ptr];
      end
      case ({w_even_push, w_even_pop})
        2'b10:   r_even_occ <= r_even_occ + OW'(1);
        2'b01:   r_even_occ <= r_even_occ - OW'(1);
        default: r_even_occ <= r_even_occ;
      endcase
    end
  end

  // Even queue storage; contents need no reset
  always_ff @(posedge clk) begin
    if (w_even_push) begin
      r_even_mem[r_even_wr_ptr] <= number;
    end
  end

  // Odd queue pointers, occupancy and last-popped value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_odd_wr_ptr <= '0;
      r_odd_rd_ptr <= '0;
      r_odd_occ    <= '0;
      r_odd_last   <= '0;
    end else if (clr) begin
      r_odd_wr_ptr <= '0;
      r_odd_rd_ptr <= '0;
      r_odd_occ    <= '0;
    end else begin
      if (w_odd_push) begin
        r_odd_wr_ptr <= r_odd_wr_ptr + PW'(1);
      end
      if (w_odd_pop) begin
        r_odd_rd_ptr <= r_odd_rd_ptr + PW'(1);
        r_odd_last   <= r_odd_mem[r_odd_rd_ptr];
      end
      case ({w_odd_push, w_odd_pop})
        2'b10:   r_odd_occ <= r_odd_occ + OW'(1);
        2'b01:   r_odd_occ <= r_odd_occ - OW'(1);
        default: r_odd_occ <= r_odd_occ;
      endcase
    end
  end

  // Odd queue storage; contents need no reset
  always_ff @(posedge clk) begin
    if (w_odd_push) begin
      r_odd_mem[r_odd_wr_ptr] <= number;
    end
  end

  // Saturating per-class accept counters, flushed by clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_even_cnt <= '0;
      r_odd_cnt  <= '0;
    end else if (clr) begin
      r_even_cnt <= '0;
      r_odd_cnt  <= '0;
    end else begin
      if (w_even_push && (r_even_cnt != CNT_MAX)) begin
        r_even_cnt <= r_even_cnt + CNT_W'(1);
      end
      if (w_odd_push && (r_odd_cnt != CNT_MAX)) begin
        r_odd_cnt <= r_odd_cnt + CNT_W'(1);
      end
    end
  end

  // Counter outputs
  always_comb begin
    even_count = r_even_cnt;
    odd_count  = r_odd_cnt;
  end

endmodule

// File: tb/tb_even_odd_sorter.sv
`timescale 1ns/1ps
// Bench for even_odd_sorter: a stimulus table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
// A second instance with CNT_W=2 shares every input to exercise counter
// saturation.
module tb_even_odd_sorter;

  localparam int DEPTH     = 4;
  localparam int CNT_W     = 8;
  localparam int CNT_MAX   = 255;
  localparam int SMALL_MAX = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       clr;
  logic       in_valid;
  logic [3:0] number;
  logic       even_ready;
  logic       odd_ready;

  logic             in_ready, even_valid, odd_valid;
  logic [3:0]       even_data, odd_data;
  logic [CNT_W-1:0] even_count, odd_count;

  logic       s_in_ready, s_even_valid, s_odd_valid;
  logic [3:0] s_even_data, s_odd_data;
  logic [1:0] s_even_count, s_odd_count;

  even_odd_sorter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .number(number),
    .in_ready(in_ready), .even_valid(even_valid), .even_ready(even_ready),
    .even_data(even_data), .odd_valid(odd_valid), .odd_ready(odd_ready),
    .odd_data(odd_data), .even_count(even_count), .odd_count(odd_count)
  );

  even_odd_sorter #(.DEPTH(DEPTH), .CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .number(number),
    .in_ready(s_in_ready), .even_valid(s_even_valid), .even_ready(even_ready),
    .even_data(s_even_data), .odd_valid(s_odd_valid), .odd_ready(odd_ready),
    .odd_data(s_odd_data), .even_count(s_even_count), .odd_count(s_odd_count)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [3:0] exp_even_q[$];
  logic [3:0] exp_odd_q[$];
  int m_even_cnt = 0;
  int m_odd_cnt  = 0;

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_even_q.delete();
    exp_odd_q.delete();
    m_even_cnt = 0;
    m_odd_cnt  = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic iv, input logic [3:0] num, input logic er,
                       input logic orr, input logic c);
    in_valid   = iv;
    number     = num;
    even_ready = er;
    odd_ready  = orr;
    clr        = c;
  endtask

  // One clock cycle: compare both DUTs with the model before the edge,
  // then advance the model by the rules for that edge.
  task automatic step();
    bit m_rdy, e_pop, o_pop, acc;
    #1;
    m_rdy = !clr && (exp_even_q.size() < DEPTH) && (exp_odd_q.size() < DEPTH);
    chk("in_ready", 32'(in_ready), 32'(m_rdy));
    chk("even_valid", 32'(even_valid), 32'(exp_even_q.size() != 0));
    chk("odd_valid", 32'(odd_valid), 32'(exp_odd_q.size() != 0));
    if (exp_even_q.size() != 0) chk("even_data", 32'(even_data), 32'(exp_even_q[0]));
    if (exp_odd_q.size() != 0) chk("odd_data", 32'(odd_data), 32'(exp_odd_q[0]));
    chk("even_count", 32'(even_count), 32'(sat(m_even_cnt, CNT_MAX)));
    chk("odd_count", 32'(odd_count), 32'(sat(m_odd_cnt, CNT_MAX)));
    chk("s_in_ready", 32'(s_in_ready), 32'(m_rdy));
    chk("s_even_valid", 32'(s_even_valid), 32'(exp_even_q.size() != 0));
    chk("s_odd_valid", 32'(s_odd_valid), 32'(exp_odd_q.size() != 0));
    if (exp_even_q.size() != 0) chk("s_even_data", 32'(s_even_data), 32'(exp_even_q[0]));
    if (exp_odd_q.size() != 0) chk("s_odd_data", 32'(s_odd_data), 32'(exp_odd_q[0]));
    chk("s_even_count", 32'(s_even_count), 32'(sat(m_even_cnt, SMALL_MAX)));
    chk("s_odd_count", 32'(s_odd_count), 32'(sat(m_odd_cnt, SMALL_MAX)));
    e_pop = !clr && (exp_even_q.size() != 0) && even_ready;
    o_pop = !clr && (exp_odd_q.size() != 0) && odd_ready;
    acc   = in_valid && m_rdy;
    @(posedge clk);
    if (clr) begin
      model_clear();
    end else begin
      if (e_pop) void'(exp_even_q.pop_front());
      if (o_pop) void'(exp_odd_q.pop_front());
      if (acc) begin
        if (number[0]) begin
          exp_odd_q.push_back(number);
          m_odd_cnt++;
        end else begin
          exp_even_q.push_back(number);
          m_even_cnt++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_even_valid", 32'(even_valid), 32'd0);
    chk("rst_odd_valid", 32'(odd_valid), 32'd0);
    chk("rst_even_count", 32'(even_count), 32'd0);
    chk("rst_odd_count", 32'(odd_count), 32'd0);
    chk("rst_even_data", 32'(even_data), 32'd0);
    chk("rst_odd_data", 32'(odd_data), 32'd0);
    rst_n = 1'b1;
    model_clear();
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    logic       iv;
    logic [3:0] num;
    logic       er;
    logic       orr;
    logic       x_rdy;
    logic       x_ev;
    logic [3:0] x_ed;
    logic       x_ov;
    logic [3:0] x_od;
    int         x_ec;
    int         x_oc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // push 2,7,0,9 with both consumers ready; expected outputs before each edge
    vecs[0] = '{1'b1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 0, 0};
    vecs[1] = '{1'b1, 4'd7, 1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 1'b0, 4'd0, 1, 0};
    vecs[2] = '{1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'd7, 1, 1};
    vecs[3] = '{1'b1, 4'd9, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 2, 1};
    vecs[4] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'd9, 2, 2};
    vecs[5] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 2, 2};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].iv, vecs[i].num, vecs[i].er, vecs[i].orr, 1'b0);
      #1;
      chk("vec_in_ready", 32'(in_ready), 32'(vecs[i].x_rdy));
      chk("vec_even_valid", 32'(even_valid), 32'(vecs[i].x_ev));
      chk("vec_odd_valid", 32'(odd_valid), 32'(vecs[i].x_ov));
      if (vecs[i].x_ev) chk("vec_even_data", 32'(even_data), 32'(vecs[i].x_ed));
      if (vecs[i].x_ov) chk("vec_odd_data", 32'(odd_data), 32'(vecs[i].x_od));
      chk("vec_even_count", 32'(even_count), 32'(vecs[i].x_ec));
      chk("vec_odd_count", 32'(odd_count), 32'(vecs[i].x_oc));
      step();
    end

    // full even queue blocks an odd sample; one pop frees it a cycle later
    do_reset();
    drive(1'b1, 4'd4, 1'b0, 1'b1, 1'b0);  step();
    drive(1'b1, 4'd6, 1'b0, 1'b1, 1'b0);  step();
    drive(1'b1, 4'd8, 1'b0, 1'b1, 1'b0);  step();
    drive(1'b1, 4'd10, 1'b0, 1'b1, 1'b0); step();
    drive(1'b1, 4'd3, 1'b0, 1'b1, 1'b0);
    #1 chk("full_blocks_odd", 32'(in_ready), 32'd0);
    step();
    #1 chk("blocked_not_accepted", 32'(odd_valid), 32'd0);
    drive(1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
    #1 chk("pop_while_full_ready", 32'(in_ready), 32'd0);
    chk("pop_while_full_head", 32'(even_data), 32'd4);
    step();
    drive(1'b1, 4'd3, 1'b0, 1'b1, 1'b0);
    #1 chk("freed_slot_ready", 32'(in_ready), 32'd1);
    step();
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    #1 chk("late_odd_valid", 32'(odd_valid), 32'd1);
    chk("late_odd_data", 32'(odd_data), 32'd3);
    chk("even_head_after_pop", 32'(even_data), 32'd6);
    step();

    // simultaneous push/pop at occupancy 2, then enough pairs to wrap pointers
    do_reset();
    drive(1'b1, 4'd4, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 4'd6, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 4'd12, 1'b1, 1'b0, 1'b0);
    #1 chk("pair_head", 32'(even_data), 32'd4);
    step();
    #1 chk("pair_next_head", 32'(even_data), 32'd6);
    for (int k = 0; k < DEPTH + 2; k++) begin
      drive(1'b1, 4'(2 * ((k + 3) % 8)), 1'b1, 1'b0, 1'b0);
      #1 chk("pair_ready", 32'(in_ready), 32'd1);
      step();
    end
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    repeat (3) step();

    // CNT_W=2 counter saturation: odd_count 1,2,3,3,3
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 4'(2 * k - 1), 1'b1, 1'b1, 1'b0);
      step();
      #1 chk("small_odd_count", 32'(s_odd_count), 32'((k < 3) ? k : 3));
    end

    // clr with a valid sample and both queues holding data
    do_reset();
    drive(1'b1, 4'd2, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 4'd3, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 4'd5, 1'b1, 1'b1, 1'b1);
    #1 chk("clr_in_ready", 32'(in_ready), 32'd0);
    step();
    drive(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    #1 chk("clr_even_valid", 32'(even_valid), 32'd0);
    chk("clr_odd_valid", 32'(odd_valid), 32'd0);
    chk("clr_even_count", 32'(even_count), 32'd0);
    chk("clr_odd_count", 32'(odd_count), 32'd0);
    step();

    // asynchronous reset pulse between edges with both queues non-empty
    do_reset();
    drive(1'b1, 4'd4, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 4'd7, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_even_valid", 32'(even_valid), 32'd0);
    chk("arst_odd_valid", 32'(odd_valid), 32'd0);
    chk("arst_even_count", 32'(even_count), 32'd0);
    chk("arst_odd_count", 32'(odd_count), 32'd0);
    chk("arst_even_data", 32'(even_data), 32'd0);
    chk("arst_odd_data", 32'(odd_data), 32'd0);
    #1 rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    repeat (2) step();

    // randomized traffic: alternate draining and congested phases
    do_reset();
    for (int c = 0; c < 600; c++) begin
      int rdy_pct;
      rdy_pct = ((c / 100) % 2 == 0) ? 80 : 25;
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
            $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 99) < rdy_pct,
            $urandom_range(0, 59) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/even_odd_sorter.md
EVEN_ODD_SORTER -- requirements
Module: even_odd_sorter

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set entries per output queue (power of two, >= 2).
REQ-002 Parameter CNT_W, default 8, SHALL set width of each accepted-number counter.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 clr  input  1  SHALL be a synchronous flush of both queues and both counters.
REQ-006 in_valid  input  1  SHALL mean number carries a valid sample.
REQ-007 number  input  4  SHALL be the sample to classify.
REQ-008 in_ready  output  1  SHALL mean the block accepts number this cycle.
REQ-009 even_valid  output  1  SHALL mean even_data holds the even-queue head.
REQ-010 even_ready  input  1  SHALL mean the consumer takes the even-queue head.
REQ-011 even_data  output  4  SHALL be the even-queue head.
REQ-012 odd_valid / odd_ready / odd_data  output / input / output  1 / 1 / 4  SHALL be the odd-queue equivalents of REQ-009..011.
REQ-013 even_count, odd_count  output  CNT_W  SHALL be saturating totals of accepted even / odd samples.

Function
REQ-014 Classification SHALL be number[0]==0 -> even, number[0]==1 -> odd; 0 is even.
REQ-015 Accept SHALL occur when in_valid && in_ready at a rising edge; the sample pushes into the queue selected by REQ-014.
REQ-016 in_ready SHALL be !clr && even_occ<DEPTH && odd_occ<DEPTH; it depends on neither in_valid nor number.
REQ-017 Each queue SHALL be a FIFO: write pointer, read pointer and occupancy counter, pointers wrapping modulo DEPTH.
REQ-018 Pop SHALL occur when x_valid && x_ready; x_valid = (x_occ != 0).
REQ-019 Latency SHALL be 1 cycle: a sample accepted at edge N appears on x_data with x_valid=1 after edge N, never combinationally in the same cycle.
REQ-020 Simultaneous push and pop on one queue SHALL leave occupancy unchanged and preserve order.
REQ-021 A pop SHALL be honoured while the queue is full; the freed slot raises in_ready one cycle later.
REQ-022 A queue full (occ==DEPTH) SHALL drop in_ready even if the incoming sample targets the other queue.
REQ-023 x_data SHALL hold its last value while x_valid=0; the bench treats it as don't-care.
REQ-024 Counters SHALL increment by 1 per accepted sample of their class and hold at 2^CNT_W-1; no wrap.
REQ-025 clr=1 SHALL, at the next edge, set both occupancies and pointers to 0 and both counters to 0.
REQ-026 clr=1 SHALL drop in_ready, and pops are ignored in that cycle; clr has priority over push and pop.
REQ-027 Storage contents SHALL need no reset; all control state is reset.

Reset
REQ-028 rst_n=0 SHALL immediately, independent of clk, force in_ready=0, even_valid=0, odd_valid=0, even_count=0, odd_count=0 and zero all pointers and occupancies; even_data/odd_data = 4'h0.
REQ-029 The first rising edge after rst_n deasserts SHALL see in_ready=1.
REQ-030 Asserting rst_n mid-operation SHALL discard queued samples; nothing is popped after release until new accepts.

Verification
REQ-031 Push 4'd2, 4'd7, 4'd0, 4'd9, consumers ready -> even stream 2,0; odd stream 7,9; even_count=2, odd_count=2.
REQ-032 even_ready=0, push 4,6,8,10 -> even_occ=4, in_ready=0 even with odd sample 3 offered; one even pop -> in_ready=1 next cycle, 3 accepted.
REQ-033 Queue at occ=2, simultaneous push 12 and pop -> occ stays 2, order kept; DEPTH+2 push/pop pairs exercise pointer wrap.
REQ-034 CNT_W=2, accept 5 odd samples -> odd_count goes 1,2,3,3,3.
REQ-035 clr=1 with in_valid=1, number=5, both queues holding data -> sample not accepted; next cycle both x_valid=0 and both counts=0.
REQ-036 rst_n pulsed low between clock edges with both queues non-empty -> outputs zero immediately; after release in_ready=1, x_valid=0.
